// File: rtl/uart_tx_queue_pkg.sv
// Shared types and constants for the UART transmit queue.
// Optional feature macro: UART_TXQ_FLUSH_EN (see uart_tx_queue.sv).
package uart_tx_queue_pkg;

  localparam int unsigned BYTE_W = 8;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSend  = 2'd1,
    StDrain = 2'd2
  } txq_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Bus-side and UART-side signals of the transmit queue.
// The slave modport is the queue itself; the master modport is whatever drives it.
// Optional feature macro: UART_TXQ_FLUSH_EN adds the flush signal.
interface uart_tx_queue_if #(
  parameter int unsigned DEPTH = 16
);
  import uart_tx_queue_pkg::*;

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [BYTE_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              uart_we;
  logic [BYTE_W-1:0] uart_data;
  logic              uart_tx_busy;
`ifdef UART_TXQ_FLUSH_EN
  logic              flush;

  modport master (
    output wr_en, wr_data, uart_tx_busy, flush,
    input  full, empty, level, overflow, uart_we, uart_data
  );

  modport slave (
    input  wr_en, wr_data, uart_tx_busy, flush,
    output full, empty, level, overflow, uart_we, uart_data
  );
`else
  modport master (
    output wr_en, wr_data, uart_tx_busy,
    input  full, empty, level, overflow, uart_we, uart_data
  );

  modport slave (
    input  wr_en, wr_data, uart_tx_busy,
    output full, empty, level, overflow, uart_we, uart_data
  );
`endif

endinterface

// File: rtl/uart_tx_queue_sync_fifo.sv
// Synchronous FIFO: register-array storage with a combinational head read,
// wrapping pointers and a separate occupancy counter.
module uart_tx_queue_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  input  logic                     i_clear,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_LVL = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;

  logic w_do_push;
  logic w_do_pop;

  // full/empty come from the registered level, so a same-cycle pop never frees a slot.
  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];

  // Clear takes priority and silently drops a concurrent push.
  assign w_do_push = i_push && !o_full && !i_clear;
  assign w_do_pop  = i_pop && !o_empty && !i_clear;

  // Storage write; no reset needed since empty slots are never read out.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap modulo DEPTH; level tracks occupancy independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= r_wr_ptr;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (ADDR_W + 1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and transmit sequencer feeding a UART over its we/data_in/tx_busy handshake.
// The UART samples we only on its internal tick, so we is held until tx_busy rises,
// then the sequencer waits for tx_busy to fall before offering the next byte.
// Optional feature macro: UART_TXQ_FLUSH_EN adds a flush input that empties the queue.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input logic            clk,
  input logic            rst,
  uart_tx_queue_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  txq_state_t        r_state;
  txq_state_t        w_state_d;
  logic [BYTE_W-1:0] r_uart_data;
  logic [BYTE_W-1:0] w_uart_data_d;
  logic              r_overflow;

  logic              w_pop;
  logic              w_clear;
  logic              w_full;
  logic              w_empty;
  logic [BYTE_W-1:0] w_head;
  logic [ADDR_W:0]   w_level;

`ifdef UART_TXQ_FLUSH_EN
  assign w_clear = bus.flush;
`else
  assign w_clear = 1'b0;
`endif

  uart_tx_queue_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.wr_en),
    .i_wdata (bus.wr_data),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Next-state: leave IDLE only with a queued byte; a same-cycle flush keeps it from leaving.
  always_comb begin
    w_state_d     = r_state;
    w_uart_data_d = r_uart_data;
    w_pop         = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_empty && !w_clear) begin
          w_pop         = 1'b1;
          w_uart_data_d = w_head;
          w_state_d     = StSend;
        end
      end
      StSend: begin
        if (bus.uart_tx_busy) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (!bus.uart_tx_busy) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and the byte presented to the UART, held stable through SEND and DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_uart_data <= '0;
    end else begin
      r_state     <= w_state_d;
      r_uart_data <= w_uart_data_d;
    end
  end

  // One-cycle pulse for a dropped push; a write dropped by flush is not an overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= bus.wr_en && w_full && !w_clear;
    end
  end

  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.level     = w_level;
  assign bus.overflow  = r_overflow;
  assign bus.uart_we   = (r_state == StSend);
  assign bus.uart_data = r_uart_data;

endmodule
